// File: rtl/mskkey_sequencer.sv
// Command sequencer for the masked key holder and shared AES core: arbitrates key loads
// against data runs, drives the holder start/modes and the core start, tracks key validity.
module mskkey_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_cmd_valid,
  output logic             key_cmd_ready,
  input  logic             key_cmd_mode_256,
  input  logic             key_cmd_inverse,
  input  logic             run_valid,
  output logic             run_ready,
  input  logic             run_inverse,
  output logic             run_done,
  output logic             run_err,
  output logic             holder_start,
  output logic             holder_mode_256,
  output logic             holder_mode_inverse,
  input  logic             holder_busy,
  input  logic             holder_lkc_req,
  output logic             aes_start,
  input  logic             aes_busy,
  output logic             key_valid,
  output logic [CNT_W-1:0] run_count
);

  typedef enum logic [2:0] {
    StIdle,
    StKeyIssue,
    StKeyWait,
    StKeyLkc,
    StRunIssue,
    StRunWait
  } state_e;

  state_e             state_q, state_d;
  logic               cfg_256_q, cfg_256_d;
  logic               cfg_inv_q, cfg_inv_d;
  logic               key_valid_q, key_valid_d;
  logic [CNT_W-1:0]   run_count_q, run_count_d;
  logic               free;

  assign free                = !holder_busy && !aes_busy;
  assign holder_mode_256     = cfg_256_q;
  assign holder_mode_inverse = cfg_inv_q;
  assign key_valid           = key_valid_q;
  assign run_count           = run_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cfg_256_q   <= 1'b0;
      cfg_inv_q   <= 1'b0;
      key_valid_q <= 1'b0;
      run_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cfg_256_q   <= cfg_256_d;
      cfg_inv_q   <= cfg_inv_d;
      key_valid_q <= key_valid_d;
      run_count_q <= run_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cfg_256_d     = cfg_256_q;
    cfg_inv_d     = cfg_inv_q;
    key_valid_d   = key_valid_q;
    run_count_d   = run_count_q;
    key_cmd_ready = 1'b0;
    run_ready     = 1'b0;
    holder_start  = 1'b0;
    aes_start     = 1'b0;
    run_done      = 1'b0;
    run_err       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Key command has priority; ready never looks at mode/direction inputs.
        key_cmd_ready = free;
        run_ready     = free && !key_cmd_valid;
        if (key_cmd_valid && key_cmd_ready) begin
          cfg_256_d   = key_cmd_mode_256;
          cfg_inv_d   = key_cmd_inverse;
          key_valid_d = 1'b0;
          run_count_d = '0;
          state_d     = StKeyIssue;
        end else if (run_valid && run_ready) begin
          if (!key_valid_q || (run_inverse && !cfg_inv_q)) begin
            run_err = 1'b1;
          end else begin
            state_d = StRunIssue;
          end
        end
      end

      StKeyIssue: begin
        holder_start = 1'b1;
        state_d      = StKeyWait;
      end

      StKeyWait: begin
        // A pending last-key request outranks the holder going idle.
        if (holder_lkc_req) begin
          state_d = StKeyLkc;
        end else if (free) begin
          key_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end

      StKeyLkc: begin
        aes_start = 1'b1;
        if (aes_busy) begin
          state_d = StKeyWait;
        end
      end

      StRunIssue: begin
        aes_start = 1'b1;
        if (aes_busy) begin
          state_d = StRunWait;
        end
      end

      StRunWait: begin
        // Completion waits for the post-run key refresh in the holder as well.
        if (free) begin
          run_done = 1'b1;
          if (run_count_q != {CNT_W{1'b1}}) begin
            run_count_d = run_count_q + CNT_W'(1);
          end
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_mskkey_sequencer.sv
// Directed bench for mskkey_sequencer: key loads, lkc path, run rejection, arbitration,
// saturating run counter and reset during a run.
module tb_mskkey_sequencer;

  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_cmd_valid;
  logic             key_cmd_ready;
  logic             key_cmd_mode_256;
  logic             key_cmd_inverse;
  logic             run_valid;
  logic             run_ready;
  logic             run_inverse;
  logic             run_done;
  logic             run_err;
  logic             holder_start;
  logic             holder_mode_256;
  logic             holder_mode_inverse;
  logic             holder_busy;
  logic             holder_lkc_req;
  logic             aes_start;
  logic             aes_busy;
  logic             key_valid;
  logic [CNT_W-1:0] run_count;

  int checks   = 0;
  int failures = 0;

  mskkey_sequencer #(.CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .key_cmd_valid       (key_cmd_valid),
    .key_cmd_ready       (key_cmd_ready),
    .key_cmd_mode_256    (key_cmd_mode_256),
    .key_cmd_inverse     (key_cmd_inverse),
    .run_valid           (run_valid),
    .run_ready           (run_ready),
    .run_inverse         (run_inverse),
    .run_done            (run_done),
    .run_err             (run_err),
    .holder_start        (holder_start),
    .holder_mode_256     (holder_mode_256),
    .holder_mode_inverse (holder_mode_inverse),
    .holder_busy         (holder_busy),
    .holder_lkc_req      (holder_lkc_req),
    .aes_start           (aes_start),
    .aes_busy            (aes_busy),
    .key_valid           (key_valid),
    .run_count           (run_count)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted forward run with a one-cycle core burst; count_exp is the value after it.
  task automatic do_run(input logic [31:0] count_exp);
    run_valid   = 1'b1;
    run_inverse = 1'b0;
    #1;
    chk("run_ready_idle", 32'(run_ready), 32'd1);
    chk("run_err_ok",     32'(run_err),   32'd0);
    step();
    run_valid = 1'b0;
    aes_busy  = 1'b1;
    #1;
    chk("run_issue_start", 32'(aes_start), 32'd1);
    step();
    aes_busy = 1'b0;
    #1;
    chk("run_done_pulse", 32'(run_done),  32'd1);
    chk("no_ready_done",  32'(key_cmd_ready | run_ready), 32'd0);
    step();
    chk("run_count", 32'(run_count), count_exp);
    chk("run_done_low", 32'(run_done), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    key_cmd_valid    = 1'b0;
    key_cmd_mode_256 = 1'b0;
    key_cmd_inverse  = 1'b0;
    run_valid        = 1'b0;
    run_inverse      = 1'b0;
    holder_busy      = 1'b0;
    holder_lkc_req   = 1'b0;
    aes_busy         = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_key_valid",  32'(key_valid),       32'd0);
    chk("rst_run_count",  32'(run_count),       32'd0);
    chk("rst_strobes",    32'({holder_start, aes_start, run_done, run_err}), 32'd0);
    chk("rst_modes",      32'({holder_mode_256, holder_mode_inverse}), 32'd0);
    chk("rst_key_ready",  32'(key_cmd_ready),   32'd1);
    chk("rst_run_ready",  32'(run_ready),       32'd1);

    // Run before any key is loaded.
    run_valid = 1'b1;
    #1;
    chk("nokey_run_err", 32'(run_err), 32'd1);
    step();
    run_valid = 1'b0;
    #1;
    chk("nokey_err_once",  32'(run_err),   32'd0);
    chk("nokey_no_start",  32'(aes_start), 32'd0);
    chk("nokey_idle",      32'(key_cmd_ready), 32'd1);

    // 128-bit forward key, holder busy for 20 cycles.
    key_cmd_valid = 1'b1;
    #1;
    chk("k128_ready",      32'(key_cmd_ready), 32'd1);
    chk("k128_no_hstart0", 32'(holder_start),  32'd0);
    step();
    key_cmd_valid = 1'b0;
    #1;
    chk("k128_hstart",     32'(holder_start),   32'd1);
    chk("k128_not_ready",  32'(key_cmd_ready),  32'd0);
    chk("k128_mode",       32'({holder_mode_256, holder_mode_inverse}), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      holder_busy = 1'b1;
      #1;
      chk("k128_hstart_once", 32'(holder_start), 32'd0);
      chk("k128_no_aes",      32'(aes_start),    32'd0);
      chk("k128_kv_low",      32'(key_valid),    32'd0);
    end
    step();
    holder_busy = 1'b0;
    #1;
    chk("k128_kv_pending", 32'(key_valid), 32'd0);
    step();
    chk("k128_key_valid",  32'(key_valid),     32'd1);
    chk("k128_idle_ready", 32'(key_cmd_ready), 32'd1);
    chk("k128_no_aes_end", 32'(aes_start),     32'd0);

    // Inverse run against a forward-only key.
    run_valid   = 1'b1;
    run_inverse = 1'b1;
    #1;
    chk("inv_run_err", 32'(run_err), 32'd1);
    step();
    run_valid = 1'b0;
    #1;
    chk("inv_err_once",  32'(run_err),   32'd0);
    chk("inv_no_start",  32'(aes_start), 32'd0);
    chk("inv_count",     32'(run_count), 32'd0);
    chk("inv_kv_kept",   32'(key_valid), 32'd1);

    // Arbitration: key (256, inverse) and inverse run together.
    key_cmd_valid    = 1'b1;
    key_cmd_mode_256 = 1'b1;
    key_cmd_inverse  = 1'b1;
    run_valid        = 1'b1;
    run_inverse      = 1'b1;
    #1;
    chk("arb_key_ready", 32'(key_cmd_ready), 32'd1);
    chk("arb_run_ready", 32'(run_ready),     32'd0);
    chk("arb_no_err",    32'(run_err),       32'd0);
    step();
    key_cmd_valid = 1'b0;
    #1;
    chk("k256_hstart",   32'(holder_start), 32'd1);
    chk("k256_modes",    32'({holder_mode_256, holder_mode_inverse}), 32'd3);
    chk("k256_kv_clr",   32'(key_valid),    32'd0);
    chk("k256_no_rready", 32'(run_ready),   32'd0);
    step();
    holder_lkc_req = 1'b1;  // lkc request while holder looks idle: lkc must win
    #1;
    chk("k256_wait_no_aes", 32'(aes_start), 32'd0);
    step();
    holder_lkc_req = 1'b0;
    holder_busy    = 1'b1;
    #1;
    chk("lkc_start",     32'(aes_start), 32'd1);
    chk("lkc_kv_low",    32'(key_valid), 32'd0);
    step();
    aes_busy = 1'b1;
    #1;
    chk("lkc_start_held", 32'(aes_start), 32'd1);
    step();
    #1;
    chk("lkc_start_drop", 32'(aes_start), 32'd0);
    step();
    holder_busy = 1'b0;
    #1;
    chk("lkc_kv_aes_busy", 32'(key_valid), 32'd0);
    step();
    aes_busy = 1'b0;
    #1;
    chk("lkc_kv_pending", 32'(key_valid), 32'd0);
    step();
    chk("k256_key_valid", 32'(key_valid), 32'd1);
    chk("k256_count_clr", 32'(run_count), 32'd0);
    chk("arb_run_ready2", 32'(run_ready), 32'd1);
    chk("arb_run_no_err", 32'(run_err),   32'd0);
    step();
    run_valid = 1'b0;
    aes_busy  = 1'b1;
    #1;
    chk("arb_run_start", 32'(aes_start), 32'd1);
    chk("arb_busy_rdy",  32'(run_ready), 32'd0);
    step();
    #1;
    chk("arb_wait_nodone", 32'(run_done), 32'd0);
    step();
    aes_busy    = 1'b0;
    holder_busy = 1'b1;
    #1;
    chk("arb_refresh_nodone", 32'(run_done), 32'd0);
    step();
    holder_busy = 1'b0;
    #1;
    chk("arb_run_done",  32'(run_done),  32'd1);
    chk("arb_cnt_pend",  32'(run_count), 32'd0);
    step();
    chk("cnt_1",         32'(run_count), 32'd1);
    chk("arb_done_low",  32'(run_done),  32'd0);

    // Saturating counter with CNT_W=2.
    do_run(32'd2);
    do_run(32'd3);
    do_run(32'd3);
    do_run(32'd3);

    // New key load clears the counter.
    key_cmd_valid    = 1'b1;
    key_cmd_mode_256 = 1'b0;
    key_cmd_inverse  = 1'b0;
    step();
    key_cmd_valid = 1'b0;
    #1;
    chk("reload_count", 32'(run_count), 32'd0);
    chk("reload_kv",    32'(key_valid), 32'd0);
    step();
    step();
    chk("reload_kv_set", 32'(key_valid), 32'd1);

    // Reset while in RUN_WAIT.
    run_valid = 1'b1;
    step();
    run_valid = 1'b0;
    aes_busy  = 1'b1;
    step();
    rst = 1'b1;
    #1;
    chk("rw_no_done", 32'(run_done), 32'd0);
    step();
    rst      = 1'b0;
    aes_busy = 1'b0;
    #1;
    chk("rstrun_kv",    32'(key_valid),     32'd0);
    chk("rstrun_done",  32'(run_done),      32'd0);
    chk("rstrun_idle",  32'(key_cmd_ready), 32'd1);
    chk("rstrun_count", 32'(run_count),     32'd0);
    run_valid   = 1'b1;
    run_inverse = 1'b0;
    #1;
    chk("rstrun_err", 32'(run_err), 32'd1);
    step();
    run_valid = 1'b0;
    #1;
    chk("rstrun_no_start", 32'(aes_start), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
